// File: rtl/hyperbus_pkg.sv
// HyperBus sequencer shared definitions: FSM states, CA bit positions, word width.
// No logic here; latency and backpressure are defined by the users of this package.
package hyperbus_pkg;

  localparam int HB_WORD_W = 16;
  localparam int HB_CA_W   = 48;

  localparam int CA_RW = 47;
  localparam int CA_AS = 46;
  localparam int CA_BT = 45;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_CA0,
    ST_CA1,
    ST_CA2,
    ST_LATENCY,
    ST_DATA,
    ST_CS_HOLD
  } hb_state_t;

endpackage

// File: rtl/hyperbus_ca_pack.sv
// Packs we/reg/word address into the 48-bit HyperBus command/address word.
// Purely combinational (0 cycles); no flow control.
module hyperbus_ca_pack
  import hyperbus_pkg::*;
(
  input  logic               we,
  input  logic               regsp,
  input  logic [31:0]        addr,
  output logic [HB_CA_W-1:0] ca
);

  always_comb begin
    ca          = '0;
    ca[CA_RW]   = ~we;
    ca[CA_AS]   = regsp;
    ca[CA_BT]   = 1'b1;           // linear burst
    ca[44:16]   = addr[31:3];
    ca[2:0]     = addr[2:0];
  end

endmodule

// File: rtl/hyperbus_seq.sv
// HyperBus burst sequencer: CS/CK gating, CA words, latency count, data streaming.
// First CA word 2 cycles after accept; write underrun stalls CK, reads have no backpressure.
module hyperbus_seq
  import hyperbus_pkg::*;
#(
  parameter int LATENCY    = 6,
  parameter int LEN_WIDTH  = 8,
  parameter int RD_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic                 req_reg_i,
  input  logic [31:0]          req_addr_i,
  input  logic [LEN_WIDTH-1:0] req_len_i,
  input  logic [HB_WORD_W-1:0] wr_data_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  output logic [HB_WORD_W-1:0] rd_data_o,
  output logic                 rd_valid_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 cs_n_o,
  output logic                 ck_en_o,
  output logic [HB_WORD_W-1:0] dq_o,
  output logic                 dq_oe_o,
  input  logic [HB_WORD_W-1:0] dq_i,
  input  logic                 rwds_i,
  input  logic                 rwds_strobe_i,
  output logic                 rwds_oe_o,
  output logic                 rwds_o
);

  localparam int LAT_W = $clog2(2*LATENCY+1);
  localparam int TO_W  = $clog2(RD_TIMEOUT+1);

  hb_state_t state, state_nxt;

  logic                 we_q, reg_q, rwds_q, aborted_q;
  logic [31:0]          addr_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LAT_W-1:0]     lat_cnt;
  logic [LEN_WIDTH:0]   wcnt;
  logic [TO_W-1:0]      to_cnt;
  logic [HB_CA_W-1:0]   ca;

  logic [LAT_W-1:0] lat_last;
  logic             last_word, wr_beat, rd_beat, rd_to;

  hyperbus_ca_pack u_ca_pack (
    .we    (we_q),
    .regsp (reg_q),
    .addr  (addr_q),
    .ca    (ca)
  );

  assign lat_last  = rwds_q ? LAT_W'(2*LATENCY-1) : LAT_W'(LATENCY-1);
  assign last_word = (wcnt == {1'b0, len_q});
  assign wr_beat   = (state == ST_DATA) &&  we_q && wr_valid_i;
  assign rd_beat   = (state == ST_DATA) && !we_q && rwds_strobe_i;
  assign rd_to     = (state == ST_DATA) && !we_q && !rwds_strobe_i &&
                     (to_cnt == TO_W'(RD_TIMEOUT-1));

  always_comb begin
    state_nxt   = state;
    req_ready_o = 1'b0;
    wr_ready_o  = 1'b0;
    cs_n_o      = 1'b0;
    ck_en_o     = 1'b0;
    dq_o        = '0;
    dq_oe_o     = 1'b0;
    rwds_oe_o   = 1'b0;
    rwds_o      = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        cs_n_o      = 1'b1;
        if (req_valid_i) state_nxt = ST_CS_SETUP;
      end
      ST_CS_SETUP: state_nxt = ST_CA0;
      ST_CA0: begin
        ck_en_o   = 1'b1;
        dq_oe_o   = 1'b1;
        dq_o      = ca[47:32];
        state_nxt = ST_CA1;
      end
      ST_CA1: begin
        ck_en_o   = 1'b1;
        dq_oe_o   = 1'b1;
        dq_o      = ca[31:16];
        state_nxt = ST_CA2;
      end
      ST_CA2: begin
        ck_en_o   = 1'b1;
        dq_oe_o   = 1'b1;
        dq_o      = ca[15:0];
        state_nxt = (we_q && reg_q) ? ST_DATA : ST_LATENCY;
      end
      ST_LATENCY: begin
        ck_en_o = 1'b1;
        if (lat_cnt == lat_last) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (we_q) begin
          // CK only toggles when a word is available, so an underrun just pauses the burst
          dq_oe_o    = 1'b1;
          rwds_oe_o  = ~reg_q;
          wr_ready_o = wr_valid_i;
          ck_en_o    = wr_valid_i;
          dq_o       = wr_data_i;
          if (wr_valid_i && last_word) state_nxt = ST_CS_HOLD;
        end else begin
          ck_en_o = 1'b1;
          if ((rd_beat && last_word) || rd_to) state_nxt = ST_CS_HOLD;
        end
      end
      ST_CS_HOLD: state_nxt = ST_IDLE;
      default: begin
        cs_n_o    = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      we_q       <= 1'b0;
      reg_q      <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      rwds_q     <= 1'b0;
      aborted_q  <= 1'b0;
      lat_cnt    <= '0;
      wcnt       <= '0;
      to_cnt     <= '0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && req_valid_i) begin
        we_q   <= req_we_i;
        reg_q  <= req_reg_i;
        addr_q <= req_addr_i;
        len_q  <= req_len_i;
      end
      if (state == ST_CA1) rwds_q <= rwds_i;
      lat_cnt <= (state == ST_LATENCY) ? lat_cnt + 1'b1 : '0;
      if (state != ST_DATA)          wcnt <= '0;
      else if (wr_beat || rd_beat)   wcnt <= wcnt + 1'b1;
      if (state != ST_DATA || we_q || rwds_strobe_i) to_cnt <= '0;
      else                                          to_cnt <= to_cnt + 1'b1;
      rd_valid_o <= rd_beat;
      if (rd_beat) rd_data_o <= dq_i;
      err_o <= rd_to;
      if (rd_to)                 aborted_q <= 1'b1;
      else if (state == ST_IDLE) aborted_q <= 1'b0;
      done_o <= (state == ST_CS_HOLD) && !aborted_q;
    end
  end

endmodule
